// File: rtl/pixel_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// pixel_timing_gen_pkg
// Shared definitions for the pixel timing generator and the timestamp /
// active-pixel memory manager it reads from. Both blocks take their bus
// widths from here, which keeps the read port and the timestamp width in step.
//
// Contents:
//   ADDR_W_DEF  pixel address width (manager raddr)
//   TS_W_DEF    timestamp and line tick counter width
//   PW_W_DEF    pulse width counter width
//   state_t     line sequencer state encoding
// -----------------------------------------------------------------------------
package pixel_timing_gen_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int TS_W_DEF   = 16;
    localparam int PW_W_DEF   = 8;

    // Line sequencer states. The encodings are fixed so that a debug probe
    // or the manager's status logic can decode them directly.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_TS  = 3'd2,
        PULSE    = 3'd3,
        LINE_END = 3'd4
    } state_t;

endpackage

// File: rtl/pixel_timing_gen_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pixel_timing_gen_pulse_stretcher
// Produces one registered pulse per load strobe. The pulse lasts
// max(width, 1) cycles. The pulse starts in the cycle after load. The done
// strobe marks the last high cycle, so the sequencer can move on without
// adding a gap.
//
// Ports:
//   clk_i   in   system clock
//   nrst_i  in   synchronous active-low reset
//   load    in   start a pulse using the current width
//   width   in   requested pulse length in cycles (0 behaves as 1)
//   pulse   out  registered pulse output
//   done    out  high during the final cycle of the pulse
// -----------------------------------------------------------------------------
module pixel_timing_gen_pulse_stretcher
    import pixel_timing_gen_pkg::*;
#(
    parameter int PW_W = PW_W_DEF
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            load,
    input  logic [PW_W-1:0] width,
    output logic            pulse,
    output logic            done
);

    logic [PW_W-1:0] count_q;

    // The remaining-cycles counter. A width of zero is promoted to one, so a
    // misprogrammed width still fires the laser once instead of skipping it.
    // The counter counts down to zero and then holds. The pulse is high
    // exactly while the count is non-zero, so it comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= (width == '0) ? PW_W'(1) : width;
        end else if (count_q != '0) begin
            count_q <= count_q - PW_W'(1);
        end
    end

    assign pulse = (count_q != '0);
    assign done  = (count_q == PW_W'(1));

endmodule

// File: rtl/pixel_timing_gen.sv
// -----------------------------------------------------------------------------
// pixel_timing_gen
// Line-by-line pixel firing sequencer. For each accepted line_sync_i it does
// the following:
//   - It walks the pixel addresses 0..npix-1 on the manager read port.
//   - It waits until the line tick counter reaches each pixel's timestamp.
//   - It fires a pulse for each active pixel.
//   - It ends the line with a one-cycle new_line_o to the manager.
//
// Ports:
//   clk_i              in   system clock
//   nrst_i             in   synchronous active-low reset
//   enable_i           in   allow new lines to start
//   line_sync_i        in   start-of-line trigger (one-cycle pulse)
//   pixels_per_line_i  in   pixels in the line, sampled at line start
//   pulse_width_i      in   pulse length in cycles (0 behaves as 1)
//   clear_err_i        in   clears overrun_o
//   timestamp_i        in   manager timestamp for raddr_o (1-cycle latency)
//   active_pixel_i     in   manager active flag for raddr_o (1-cycle latency)
//   raddr_o            out  manager read address
//   pixel_pulse_o      out  pixel fire pulse
//   new_line_o         out  one-cycle end-of-line strobe
//   line_busy_o        out  high while a line is in progress
//   overrun_o          out  sticky: line_sync_i arrived while busy
// -----------------------------------------------------------------------------
module pixel_timing_gen
    import pixel_timing_gen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int PW_W   = PW_W_DEF
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              enable_i,
    input  logic              line_sync_i,
    input  logic [ADDR_W-1:0] pixels_per_line_i,
    input  logic [PW_W-1:0]   pulse_width_i,
    input  logic              clear_err_i,
    input  logic [TS_W-1:0]   timestamp_i,
    input  logic              active_pixel_i,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              pixel_pulse_o,
    output logic              new_line_o,
    output logic              line_busy_o,
    output logic              overrun_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] npix_q;
    logic [TS_W-1:0]   tick_q;
    logic              overrun_q;

    logic              start_line;
    logic              load_pulse;
    logic              advance;
    logic              last_pixel;
    logic              pulse_done;

    assign start_line = (state_q == IDLE) && line_sync_i && enable_i;
    assign last_pixel = (raddr_q == npix_q - ADDR_W'(1));

    // Next-state logic. "Advance" is a transition action, not a state. It is
    // shared by the skip path (inactive pixel in WAIT_TS) and the end of a
    // pulse. After an advance the sequencer goes to FETCH for the next pixel,
    // or to LINE_END if this was the last pixel. An empty line goes straight
    // from IDLE to LINE_END. That decision uses the live input because npix_q
    // is only being loaded in the same cycle.
    always_comb begin
        state_d    = state_q;
        load_pulse = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_line) begin
                    state_d = (pixels_per_line_i == '0) ? LINE_END : FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_TS;
            end
            WAIT_TS: begin
                if (tick_q >= timestamp_i) begin
                    if (active_pixel_i) begin
                        load_pulse = 1'b1;
                        state_d    = PULSE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (pulse_done) begin
                    advance = 1'b1;
                end
            end
            LINE_END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (advance) begin
            state_d = last_pixel ? LINE_END : FETCH;
        end
    end

    // State register and the per-line registers:
    //   - The address counter restarts at each line and steps once per
    //     advance. It does not step on the last pixel, so raddr_o shows the
    //     final pixel until the next line starts.
    //   - The tick counter is zeroed at line start and counts every busy
    //     cycle. It saturates so that a very long line cannot wrap around
    //     and fire early pixels again.
    //   - The overrun flag is sticky. When a new overrun and clear_err_i
    //     happen in the same cycle, the new overrun wins.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            npix_q    <= '0;
            tick_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_line) begin
                raddr_q <= '0;
                npix_q  <= pixels_per_line_i;
            end else if (advance && !last_pixel) begin
                raddr_q <= raddr_q + ADDR_W'(1);
            end

            if (start_line) begin
                tick_q <= '0;
            end else if ((state_q != IDLE) && (tick_q != '1)) begin
                tick_q <= tick_q + TS_W'(1);
            end

            if (line_sync_i && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clear_err_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    pixel_timing_gen_pulse_stretcher #(
        .PW_W (PW_W)
    ) u_pulse_stretcher (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .load   (load_pulse),
        .width  (pulse_width_i),
        .pulse  (pixel_pulse_o),
        .done   (pulse_done)
    );

    assign raddr_o     = raddr_q;
    assign new_line_o  = (state_q == LINE_END);
    assign line_busy_o = (state_q != IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_pixel_timing_gen
// Directed bench for pixel_timing_gen. The manager read port is modelled by
// two small arrays read with one cycle of latency. Each line runs cycle by
// cycle against hand-derived tables:
//   - the cycle each pulse starts,
//   - the first cycle raddr_o shows each pixel,
//   - the cycle of new_line_o.
// Cycle 1 is the first cycle after the clock edge that accepts line_sync_i.
// -----------------------------------------------------------------------------
module tb_pixel_timing_gen;
    import pixel_timing_gen_pkg::*;

    localparam int ADDR_W = 9;
    localparam int TS_W   = 16;
    localparam int PW_W   = 8;

    logic              clk = 1'b0;
    logic              nrst;
    logic              enable;
    logic              line_sync;
    logic [ADDR_W-1:0] pixels_per_line;
    logic [PW_W-1:0]   pulse_width;
    logic              clear_err;
    logic [TS_W-1:0]   timestamp;
    logic              active_pixel;
    logic [ADDR_W-1:0] raddr;
    logic              pixel_pulse;
    logic              new_line;
    logic              line_busy;
    logic              overrun;

    logic [TS_W-1:0]   ts_mem [8];
    logic              act_mem [8];

    int   checks = 0;
    int   errors = 0;
    int   exp_ps  [4];
    int   exp_adv [4];
    logic exp_ovr;

    pixel_timing_gen #(
        .ADDR_W (ADDR_W),
        .TS_W   (TS_W),
        .PW_W   (PW_W)
    ) dut (
        .clk_i             (clk),
        .nrst_i            (nrst),
        .enable_i          (enable),
        .line_sync_i       (line_sync),
        .pixels_per_line_i (pixels_per_line),
        .pulse_width_i     (pulse_width),
        .clear_err_i       (clear_err),
        .timestamp_i       (timestamp),
        .active_pixel_i    (active_pixel),
        .raddr_o           (raddr),
        .pixel_pulse_o     (pixel_pulse),
        .new_line_o        (new_line),
        .line_busy_o       (line_busy),
        .overrun_o         (overrun)
    );

    always #5 clk = ~clk;

    // Manager read port model. The data for an address appears in the cycle
    // after that address is presented.
    always @(posedge clk) begin
        timestamp    <= ts_mem[raddr[2:0]];
        active_pixel <= act_mem[raddr[2:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the per-cycle control inputs and updates the expected overrun
    // flag. When a set and a clear arrive in the same cycle, the set wins.
    task automatic applyStimulus(input logic sync, input logic clr, input logic busy_now);
        line_sync = sync;
        clear_err = clr;
        if (sync && busy_now) exp_ovr = 1'b1;
        else if (clr)         exp_ovr = 1'b0;
    endtask

    task automatic checkAll(input string tag, input logic e_pulse, input logic e_nl,
                            input logic e_busy, input int e_addr);
        checkOutput($sformatf("%s pulse", tag), 32'(pixel_pulse), 32'(e_pulse));
        checkOutput($sformatf("%s new_line", tag), 32'(new_line), 32'(e_nl));
        checkOutput($sformatf("%s busy", tag), 32'(line_busy), 32'(e_busy));
        checkOutput($sformatf("%s raddr", tag), 32'(raddr), 32'(e_addr));
        checkOutput($sformatf("%s overrun", tag), 32'(overrun), 32'(exp_ovr));
    endtask

    // Starts one line and checks every cycle through two cycles past
    // new_line_o. Mid-line disturbances are placed on specific cycles:
    //   - a second sync,
    //   - a clear,
    //   - enable falling,
    //   - pixels_per_line_i being overwritten right after acceptance.
    // None of these may change the line in progress.
    task automatic runLine(input string name, input int w, input int npix, input int end_c,
                           input int sync_at, input int clr_at, input int en_off_at);
        int eff_w;
        eff_w = (w == 0) ? 1 : w;
        $display("[TB] line: %s", name);
        pulse_width     = PW_W'(w);
        pixels_per_line = ADDR_W'(npix);
        enable          = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1);
        pixels_per_line = ADDR_W'(1);
        for (int c = 1; c <= end_c + 2; c++) begin
            logic e_pulse;
            int   e_addr;
            e_pulse = 1'b0;
            e_addr  = 0;
            for (int i = 0; i < 4; i++) begin
                if (exp_ps[i] > 0 && c >= exp_ps[i] && c < exp_ps[i] + eff_w) e_pulse = 1'b1;
                if (exp_adv[i] <= c) e_addr = i;
            end
            checkAll($sformatf("%s@%0d", name, c), e_pulse, c == end_c, c <= end_c, e_addr);
            applyStimulus(c == sync_at, c == clr_at, c <= end_c);
            if (c == en_off_at) enable = 1'b0;
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        enable = 1'b1;
    endtask

    task automatic loadBasic();
        for (int i = 0; i < 8; i++) begin
            ts_mem[i]  = TS_W'(10 * (i + 1));
            act_mem[i] = 1'b1;
        end
    endtask

    initial begin
        nrst            = 1'b0;
        enable          = 1'b0;
        line_sync       = 1'b0;
        clear_err       = 1'b0;
        pixels_per_line = '0;
        pulse_width     = '0;
        exp_ovr         = 1'b0;
        loadBasic();
        step();
        step();
        checkAll("reset", 1'b0, 1'b0, 1'b0, 0);
        nrst = 1'b1;
        step();

        // Four pixels at ticks 10/20/30/40, width 3. Enable drops mid-line,
        // and the line still completes.
        exp_ps  = '{12, 22, 32, 42};
        exp_adv = '{1, 15, 25, 35};
        runLine("basic", 3, 4, 45, 0, 0, 5);

        // Pixel 1 inactive: no pulse for it, but the address still visits 1.
        act_mem[1] = 1'b0;
        exp_ps  = '{12, 0, 32, 42};
        exp_adv = '{1, 15, 22, 35};
        runLine("skip", 3, 4, 45, 0, 0, 0);
        act_mem[1] = 1'b1;

        // Width 0 behaves as 1: one-cycle pulses, with the addresses shifted
        // earlier accordingly.
        exp_ps  = '{12, 22, 32, 42};
        exp_adv = '{1, 13, 23, 33};
        runLine("width0", 0, 4, 43, 0, 0, 0);

        // Empty line: new_line_o in the first cycle after acceptance.
        exp_ps  = '{0, 0, 0, 0};
        exp_adv = '{1, 999, 999, 999};
        runLine("npix0", 3, 0, 1, 0, 0, 0);

        // Timestamps already past: pulses 3 cycles apart (1 high, 2 low).
        for (int i = 0; i < 8; i++) ts_mem[i] = '0;
        exp_ps  = '{3, 6, 9, 0};
        exp_adv = '{1, 4, 7, 999};
        runLine("late", 1, 3, 10, 0, 0, 0);

        // Overrun tests:
        //   - A mid-line sync sets the flag and the line is unchanged.
        //   - A set and a clear together keep the flag set.
        //   - A lone clear drops the flag.
        //   - A sync in the LINE_END cycle counts as an overrun and is not
        //     accepted.
        loadBasic();
        exp_ps  = '{12, 22, 32, 42};
        exp_adv = '{1, 15, 25, 35};
        runLine("ovr_set", 3, 4, 45, 20, 0, 0);
        runLine("ovr_setwins", 3, 4, 45, 30, 30, 0);
        for (int i = 0; i < 8; i++) ts_mem[i] = '0;
        exp_ps  = '{3, 6, 9, 0};
        exp_adv = '{1, 4, 7, 999};
        runLine("ovr_clear", 1, 3, 10, 0, 2, 0);
        exp_ps  = '{0, 0, 0, 0};
        exp_adv = '{1, 999, 999, 999};
        runLine("ovr_lineend", 3, 0, 1, 1, 0, 0);

        // Reset during the pulse of pixel 1 (cycle 23). The overrun flag from
        // the previous line is also set at this point.
        $display("[TB] reset mid-line");
        loadBasic();
        pulse_width     = PW_W'(3);
        pixels_per_line = ADDR_W'(4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int c = 1; c < 23; c++) step();
        checkAll("pre_reset", 1'b1, 1'b0, 1'b1, 1);
        nrst = 1'b0;
        step();
        nrst    = 1'b1;
        exp_ovr = 1'b0;
        checkAll("in_reset", 1'b0, 1'b0, 1'b0, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            checkAll($sformatf("post_reset%0d", c), 1'b0, 1'b0, 1'b0, 0);
        end

        // With enable low, a sync is ignored and does not count as an overrun.
        $display("[TB] enable low");
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checkAll($sformatf("disabled%0d", c), 1'b0, 1'b0, 1'b0, 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
